uart_tx_frame_serializer: RTL

Parametrised UART transmit engine that replaces the bare shift-register serializer. It accepts a parallel word on a valid/busy handshake and emits a complete frame on TX_OUT: start bit, DATA_WIDTH data bits, optional parity, and 1 or 2 stop bits. Bit timing comes from an external single-cycle baud tick. The block sits between the TX FIFO/register file and the UART pin mux.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_parity_calc.sv | 14 +
 rtl/uart_tx_frame_serializer.sv | 103 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and line-level constants for the TX serializer and RX checker.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_t;

  // Frame options captured at acceptance. Parity type is folded into the latched parity bit.
  typedef struct packed {
    logic par_en;
    logic stop2;
  } tx_cfg_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: XOR reduction of the word, inverted for odd parity.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// UART transmit engine: start, DATA_WIDTH data bits, optional parity, 1 or 2 stop bits,
// paced by an external baud tick. All outputs are registered.
module uart_tx_frame_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  baud_tick,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = $clog2(DATA_WIDTH);

  tx_state_t             state, state_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]         cnt, cnt_n;
  tx_cfg_t               cfg, cfg_n;
  logic                  par_q, par_n, par_calc;
  logic                  tx_n, done_n, last_bit;

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .par_bit (par_calc)
  );

  assign last_bit = (cnt == CW'(DATA_WIDTH-1));

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    cfg_n   = cfg;
    par_n   = par_q;
    case (state)
      IDLE: if (Data_Valid) begin
        state_n = START;
        shreg_n = P_DATA;
        cfg_n   = '{par_en: PAR_EN, stop2: STOP2};
        par_n   = par_calc;
      end
      START: if (baud_tick) begin
        state_n = DATA;
        cnt_n   = '0;
      end
      DATA: if (baud_tick) begin
        shreg_n = MSB_FIRST ? {shreg[DATA_WIDTH-2:0], 1'b0} : {1'b0, shreg[DATA_WIDTH-1:1]};
        cnt_n   = cnt + CW'(1);
        if (last_bit) state_n = cfg.par_en ? PARITY : STOP1;
      end
      PARITY: if (baud_tick) state_n = STOP1;
      STOP1:  if (baud_tick) state_n = cfg.stop2 ? uart_pkg::STOP2 : IDLE;
      uart_pkg::STOP2: if (baud_tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Line level is a function of the next state so TX_OUT comes straight from a flop.
  always_comb begin
    tx_n = LINE_IDLE;
    case (state_n)
      START:  tx_n = START_BIT;
      DATA:   tx_n = MSB_FIRST ? shreg_n[DATA_WIDTH-1] : shreg_n[0];
      PARITY: tx_n = par_n;
      default: tx_n = LINE_IDLE;
    endcase
  end

  assign done_n = (state != IDLE) && (state_n == IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      cfg        <= '0;
      par_q      <= 1'b0;
      TX_OUT     <= LINE_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      cfg        <= cfg_n;
      par_q      <= par_n;
      TX_OUT     <= tx_n;
      busy       <= (state_n != IDLE);
      frame_done <= done_n;
    end
  end

endmodule
